// File: rtl/serv_alu_gen_pkg.sv
// Shared encodings for the bit-serial ALU: op select, FSM states, op-class helpers.
package serv_alu_gen_pkg;

   typedef logic [2:0] alu_op_t;

   localparam alu_op_t ALU_OP_ADD = 3'b000;
   localparam alu_op_t ALU_OP_SR  = 3'b001;
   localparam alu_op_t ALU_OP_SL  = 3'b010;
   localparam alu_op_t ALU_OP_XOR = 3'b011;
   localparam alu_op_t ALU_OP_OR  = 3'b100;
   localparam alu_op_t ALU_OP_AND = 3'b101;
   localparam alu_op_t ALU_OP_SLT = 3'b110;
   localparam alu_op_t ALU_OP_EQ  = 3'b111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_OUT  = 2'd2;

   // Ops whose result leaves in a second WIDTH-cycle phase.
   function automatic logic op_has_out(input alu_op_t op);
      return (op == ALU_OP_SR) || (op == ALU_OP_SL) || (op == ALU_OP_SLT);
   endfunction

   function automatic logic op_emits_run(input alu_op_t op);
      return (op == ALU_OP_ADD) || (op == ALU_OP_XOR) ||
             (op == ALU_OP_OR)  || (op == ALU_OP_AND);
   endfunction

endpackage

// File: rtl/serv_alu_gen_if.sv
// Serial operand/result bundle between register file, ALU and rd writeback.
// SERV_ALU_GEN_ZERO_FLAG_EN adds the o_zero result flag.
interface serv_alu_gen_if;
   import serv_alu_gen_pkg::*;

   logic    i_start;
   alu_op_t i_op;
   logic    i_sub;
   logic    i_signed;
   logic    i_rs1;
   logic    i_op_b;
   logic    o_rd;
   logic    o_rd_valid;
   logic    o_cmp;
   logic    o_busy;
   logic    o_done;
`ifdef SERV_ALU_GEN_ZERO_FLAG_EN
   logic    o_zero;
`endif

   modport master (
      output i_start, i_op, i_sub, i_signed, i_rs1, i_op_b,
      input  o_rd, o_rd_valid, o_cmp, o_busy, o_done
`ifdef SERV_ALU_GEN_ZERO_FLAG_EN
      , input o_zero
`endif
   );

   modport slave (
      input  i_start, i_op, i_sub, i_signed, i_rs1, i_op_b,
      output o_rd, o_rd_valid, o_cmp, o_busy, o_done
`ifdef SERV_ALU_GEN_ZERO_FLAG_EN
      , output o_zero
`endif
   );

endinterface

// File: rtl/serv_alu_gen_shbuf.sv
// Serial-in operand buffer and shift-amount register; selects output bit k of
// a left or right (logical/arithmetic) shift of the buffered word.
module serv_alu_gen_shbuf #(
   parameter  int WIDTH   = 32,
   localparam int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               i_rst,
   input  logic               i_shift_en,
   input  logic               i_rs1,
   input  logic               i_op_b,
   input  logic [SHAMT_W-1:0] i_bit_idx,
   input  logic               i_left,
   input  logic               i_arith,
   output logic               o_bit
);

   localparam logic [SHAMT_W-1:0] SHAMT_BITS = SHAMT_W'(SHAMT_W);

   logic [WIDTH-1:0]   data_q;
   logic [SHAMT_W-1:0] shamt_q;
   logic [SHAMT_W:0]   sr_idx;
   logic [SHAMT_W-1:0] sl_idx;

   // NOTE: the data buffer is fully overwritten before every use, so it carries
   // no reset; only the control-like shamt register is cleared.
   always_ff @(posedge clk) begin
      if (i_shift_en) begin
         data_q <= {i_rs1, data_q[WIDTH-1:1]};
      end
   end

   // shamt arrives LSB first in the opening SHAMT_W bits of op_b.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         shamt_q <= '0;
      end else if (i_shift_en && (i_bit_idx < SHAMT_BITS)) begin
         shamt_q <= {i_op_b, shamt_q[SHAMT_W-1:1]};
      end
   end

   always_comb begin
      sr_idx = {1'b0, i_bit_idx} + {1'b0, shamt_q};
      sl_idx = i_bit_idx - shamt_q;
      o_bit  = 1'b0;
      if (i_left) begin
         o_bit = (i_bit_idx >= shamt_q) ? data_q[sl_idx] : 1'b0;
      end else if (sr_idx[SHAMT_W]) begin
         o_bit = i_arith & data_q[WIDTH-1];
      end else begin
         o_bit = data_q[sr_idx[SHAMT_W-1:0]];
      end
   end

endmodule

// File: rtl/serv_alu_gen.sv
// Bit-serial ALU: add/sub, logic, shifts, SLT, EQ over WIDTH-cycle LSB-first streams.
// Define SERV_ALU_GEN_ZERO_FLAG_EN to add the o_zero result flag.
module serv_alu_gen
   import serv_alu_gen_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic           clk,
   input logic           i_rst,
   serv_alu_gen_if.slave bus
);

   localparam int SHAMT_W = $clog2(WIDTH);
   localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);
   localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);

   logic [1:0]         state_q, state_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   alu_op_t            op_q, op_d;
   logic               sub_q, sub_d;
   logic               signed_q, signed_d;
   logic               carry_q, carry_d;
   logic               eq_q, eq_d;
   logic               lt_q, lt_d;
   logic               cmp_q, cmp_d;

   logic    start, run, out_ph, last, first;
   alu_op_t op_e;
   logic    sub_e, signed_e, sub_add, has_out;
   logic    b_x, cin, sum, cout, lt_fin, eq_acc, run_bit, sh_bit, rd, rd_valid, done;

   // The i_start cycle is RUN bit 0, so it works off the live control inputs.
   assign start    = ~i_rst & (state_q == ST_IDLE) & bus.i_start;
   assign run      = ~i_rst & (start | (state_q == ST_RUN));
   assign out_ph   = ~i_rst & (state_q == ST_OUT);
   assign first    = (cnt_q == '0);
   assign last     = (cnt_q == CNT_LAST);
   assign op_e     = start ? bus.i_op     : op_q;
   assign sub_e    = start ? bus.i_sub    : sub_q;
   assign signed_e = start ? bus.i_signed : signed_q;
   assign has_out  = op_has_out(op_e);

   assign sub_add = sub_e | (op_e == ALU_OP_SLT);
   assign b_x     = bus.i_op_b ^ sub_add;
   assign cin     = first ? sub_add : carry_q;
   assign sum     = bus.i_rs1 ^ b_x ^ cin;
   assign cout    = (bus.i_rs1 & b_x) | (cin & (bus.i_rs1 ^ b_x));
   assign lt_fin  = signed_e ? (sum ^ cin ^ cout) : ~cout;
   assign eq_acc  = (first | eq_q) & ~(bus.i_rs1 ^ bus.i_op_b);

   always_comb begin
      case (op_e)
         ALU_OP_ADD: run_bit = sum;
         ALU_OP_XOR: run_bit = bus.i_rs1 ^ bus.i_op_b;
         ALU_OP_OR:  run_bit = bus.i_rs1 | bus.i_op_b;
         ALU_OP_AND: run_bit = bus.i_rs1 & bus.i_op_b;
         default:    run_bit = 1'b0;
      endcase
   end

   serv_alu_gen_shbuf #(.WIDTH(WIDTH)) u_shbuf (
      .clk        (clk),
      .i_rst      (i_rst),
      .i_shift_en (run),
      .i_rs1      (bus.i_rs1),
      .i_op_b     (bus.i_op_b),
      .i_bit_idx  (cnt_q),
      .i_left     (op_q == ALU_OP_SL),
      .i_arith    (signed_q),
      .o_bit      (sh_bit)
   );

   always_comb begin
      rd = 1'b0;
      if (run && op_emits_run(op_e)) begin
         rd = run_bit;
      end else if (out_ph) begin
         rd = (op_q == ALU_OP_SLT) ? (first & lt_q) : sh_bit;
      end
   end

   assign rd_valid = (run & op_emits_run(op_e)) | out_ph;
   assign done     = (run & last & ~has_out) | (out_ph & last);

   assign bus.o_rd       = rd;
   assign bus.o_rd_valid = rd_valid;
   assign bus.o_done     = done;
   assign bus.o_busy     = run | out_ph;
   assign bus.o_cmp      = cmp_q;

   always_comb begin
      // NOTE: every _d starts from its _q so no branch can infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      sub_d    = sub_q;
      signed_d = signed_q;
      carry_d  = carry_q;
      eq_d     = eq_q;
      lt_d     = lt_q;
      cmp_d    = cmp_q;
      if (start) begin
         state_d  = ST_RUN;
         op_d     = bus.i_op;
         sub_d    = bus.i_sub;
         signed_d = bus.i_signed;
         cmp_d    = 1'b0;
      end
      if (run) begin
         cnt_d   = cnt_q + CNT_ONE;
         carry_d = cout;
         eq_d    = eq_acc;
         if (last) begin
            state_d = has_out ? ST_OUT : ST_IDLE;
            if (op_e == ALU_OP_EQ) cmp_d = eq_acc;
            if (op_e == ALU_OP_SLT) begin
               cmp_d = lt_fin;
               lt_d  = lt_fin;
            end
         end
      end
      if (out_ph) begin
         cnt_d = cnt_q + CNT_ONE;
         if (last) state_d = ST_IDLE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_q     <= ALU_OP_ADD;
         sub_q    <= 1'b0;
         signed_q <= 1'b0;
         carry_q  <= 1'b0;
         eq_q     <= 1'b0;
         lt_q     <= 1'b0;
         cmp_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         sub_q    <= sub_d;
         signed_q <= signed_d;
         carry_q  <= carry_d;
         eq_q     <= eq_d;
         lt_q     <= lt_d;
         cmp_q    <= cmp_d;
      end
   end

`ifdef SERV_ALU_GEN_ZERO_FLAG_EN
   logic nz_q, nz_d, zero_q, zero_d;

   // nz_q remembers any 1 emitted so far; it is clear again after every done.
   always_comb begin
      nz_d   = done ? 1'b0 : (nz_q | (rd_valid & rd));
      zero_d = zero_q;
      if (start) zero_d = 1'b0;
      if (done) begin
         zero_d = (op_e == ALU_OP_EQ) ? ~eq_acc : ~(nz_q | (rd_valid & rd));
      end
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         nz_q   <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         nz_q   <= nz_d;
         zero_q <= zero_d;
      end
   end

   assign bus.o_zero = zero_q;
`endif

endmodule

// File: tb/tb_serv_alu_gen.sv
// Self-checking bench for serv_alu_gen: directed cases plus random ops against
// a word-level reference model.
module tb_serv_alu_gen;

   localparam int W = 32;
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SR  = 3'b001;
   localparam logic [2:0] OP_SL  = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_AND = 3'b101;
   localparam logic [2:0] OP_SLT = 3'b110;
   localparam logic [2:0] OP_EQ  = 3'b111;

   logic clk = 1'b0;
   logic i_rst;

   serv_alu_gen_if bus ();

   serv_alu_gen #(.WIDTH(W)) dut (
      .clk   (clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total  = 0;
   int passed = 0;

   logic [W-1:0] got_word;
   int nvalid, first_v, done_cyc, ndone;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Returns {cmp, result word} computed at word level.
   function automatic logic [W:0] model(input logic [2:0] op, input logic sub, input logic sgn,
                                        input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      logic c;
      int sh;
      r  = '0;
      c  = 1'b0;
      sh = int'(b % W);
      case (op)
         OP_ADD: r = sub ? a - b : a + b;
         OP_SR:  r = sgn ? W'($signed(a) >>> sh) : a >> sh;
         OP_SL:  r = a << sh;
         OP_XOR: r = a ^ b;
         OP_OR:  r = a | b;
         OP_AND: r = a & b;
         OP_SLT: begin
            c = sgn ? ($signed(a) < $signed(b)) : (a < b);
            r = {{(W-1){1'b0}}, c};
         end
         default: c = (a == b);
      endcase
      return {c, r};
   endfunction

   // Streams one operation; noise on control inputs while busy must be ignored.
   task automatic do_op(input logic [2:0] op, input logic sub, input logic sgn,
                        input logic [W-1:0] a, input logic [W-1:0] b, input int rst_at);
      got_word = '0;
      nvalid   = 0;
      first_v  = -1;
      done_cyc = -1;
      ndone    = 0;
      for (int c = 0; c < 3 * W; c++) begin
         @(posedge clk);
         #1;
         i_rst        = (c == rst_at);
         bus.i_start  = (c == 0) ? 1'b1 : 1'($urandom);
         bus.i_op     = (c == 0) ? op  : 3'($urandom);
         bus.i_sub    = (c == 0) ? sub : 1'($urandom);
         bus.i_signed = (c == 0) ? sgn : 1'($urandom);
         bus.i_rs1    = (c < W) ? a[c] : 1'($urandom);
         bus.i_op_b   = (c < W) ? b[c] : 1'($urandom);
         @(negedge clk);
         if (bus.o_rd_valid) begin
            if (nvalid < W) got_word[nvalid] = bus.o_rd;
            if (first_v < 0) first_v = c;
            nvalid++;
         end
         if (bus.o_done) begin
            ndone++;
            done_cyc = c;
         end
         if (bus.o_done || c == rst_at) break;
      end
      bus.i_start = 1'b0;
   endtask

   task automatic run_check(input string name, input logic [2:0] op, input logic sub,
                            input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit post);
      logic [W:0] m;
      bit outp;
      m    = model(op, sub, sgn, a, b);
      outp = (op == OP_SR) || (op == OP_SL) || (op == OP_SLT);
      do_op(op, sub, sgn, a, b, -1);
      check({name, " done_count"}, ndone, 1);
      check({name, " done_cycle"}, done_cyc, outp ? 2 * W - 1 : W - 1);
      check({name, " valid_count"}, nvalid, (op == OP_EQ) ? 0 : W);
      if (op != OP_EQ) begin
         check({name, " first_valid"}, first_v, outp ? W : 0);
         check({name, " word"}, got_word, m[W-1:0]);
      end
      if (post) begin
         @(posedge clk);
         #1;
         bus.i_start = 1'b0;
         @(negedge clk);
         check({name, " busy_after"}, bus.o_busy, 0);
         check({name, " done_after"}, bus.o_done, 0);
         if (op == OP_EQ || op == OP_SLT) check({name, " cmp"}, bus.o_cmp, m[W]);
`ifdef SERV_ALU_GEN_ZERO_FLAG_EN
         check({name, " zero"}, bus.o_zero, (op == OP_EQ) ? !m[W] : (m[W-1:0] == '0));
`endif
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst        = 1'b1;
      bus.i_start  = 1'b0;
      bus.i_op     = OP_ADD;
      bus.i_sub    = 1'b0;
      bus.i_signed = 1'b0;
      bus.i_rs1    = 1'b0;
      bus.i_op_b   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst busy", bus.o_busy, 0);
      check("rst valid", bus.o_rd_valid, 0);
      check("rst cmp", bus.o_cmp, 0);
      check("rst done", bus.o_done, 0);
      @(posedge clk);
      #1;
      i_rst = 1'b0;
      @(negedge clk);
      check("idle rd", bus.o_rd, 0);
      check("idle busy", bus.o_busy, 0);
`ifdef SERV_ALU_GEN_ZERO_FLAG_EN
      check("rst zero", bus.o_zero, 0);
`endif

      run_check("add 5+7", OP_ADD, 1'b0, 1'b0, 32'd5, 32'd7, 1'b1);
      check("add 5+7 literal", got_word, 32'd12);
      run_check("sub 3-5", OP_ADD, 1'b1, 1'b0, 32'd3, 32'd5, 1'b1);
      check("sub literal", got_word, 32'hFFFF_FFFE);
      run_check("slt signed", OP_SLT, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b1);
      check("slt signed literal", got_word, 32'd1);
      run_check("slt unsigned", OP_SLT, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1);
      check("slt unsigned literal", got_word, 32'd0);
      run_check("sra 4", OP_SR, 1'b0, 1'b1, 32'h8000_0010, 32'd4, 1'b1);
      check("sra literal", got_word, 32'hF800_0001);
      run_check("srl 4", OP_SR, 1'b0, 1'b0, 32'h8000_0010, 32'd4, 1'b1);
      check("srl literal", got_word, 32'h0800_0001);
      run_check("sll 31", OP_SL, 1'b0, 1'b0, 32'd1, 32'd31, 1'b1);
      check("sll literal", got_word, 32'h8000_0000);
      run_check("sr shamt0", OP_SR, 1'b0, 1'b1, 32'h9234_5678, 32'hFFFF_FFE0, 1'b1);
      check("sr shamt0 literal", got_word, 32'h9234_5678);
      run_check("sl shamt0", OP_SL, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0060, 1'b1);
      check("sl shamt0 literal", got_word, 32'h1234_5678);
      run_check("eq same", OP_EQ, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
      check("eq same literal", bus.o_cmp, 1);
      run_check("eq diff", OP_EQ, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h5EAD_BEEF, 1'b1);
      check("eq diff literal", bus.o_cmp, 0);
      run_check("add 1+ffffffff", OP_ADD, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, 1'b1);
      run_check("xor a^b", OP_XOR, 1'b0, 1'b0, 32'hA, 32'hB, 1'b1);

      // Back-to-back: second start lands in the cycle right after o_done.
      run_check("b2b first", OP_OR, 1'b0, 1'b0, 32'h00F0_0F00, 32'h0F00_00F0, 1'b0);
      run_check("b2b second", OP_SL, 1'b0, 1'b0, 32'h0000_00FF, 32'd8, 1'b1);

      // Abort SLT (cmp already 1) in OUT cycle 10.
      do_op(OP_SLT, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, W + 10);
      check("abort no done", ndone, 0);
      @(posedge clk);
      #1;
      i_rst       = 1'b0;
      bus.i_start = 1'b0;
      @(negedge clk);
      check("abort rd", bus.o_rd, 0);
      check("abort valid", bus.o_rd_valid, 0);
      check("abort busy", bus.o_busy, 0);
      check("abort done", bus.o_done, 0);
      check("abort cmp", bus.o_cmp, 0);
      run_check("add after abort", OP_ADD, 1'b0, 1'b0, 32'd1, 32'd1, 1'b1);
      check("add after abort literal", got_word, 32'd2);

      for (int i = 0; i < 40; i++) begin
         run_check($sformatf("rand%0d", i), 3'($urandom), 1'($urandom), 1'($urandom),
                   $urandom, $urandom, 1'($urandom));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
